rng_xorshift_core: RTL
======================

# rng_xorshift_core

Random-word generator stage that feeds the RNG AXI4-Lite register slave. It runs a 32-bit xorshift (13/17/5) state machine and buffers its output in a small FIFO. The FIFO presents words on a valid/ready port, and the slave pops one word per data-register read. Seed load, enable and status come from the slave's control registers.

## Interface
Parameters:
- FIFO_DEPTH, 4, output buffer entries; power of two, 2..16
- WARMUP_WORDS, 0, words generated and discarded after each seed load; 0..255
- DEFAULT_SEED, 32'h2545F491, seed used out of reset and in place of a zero seed

Ports:
- s00_axi_aclk  in  1  sole clock; all logic on its rising edge
- s00_axi_aresetn  in  1  asynchronous active-low reset
- seed_i  in  32  seed value, sampled when seed_load_i=1
- seed_load_i  in  1  single-cycle pulse; reseeds the generator and flushes the FIFO
- enable_i  in  1  level; generation allowed while 1
- rnd_data_o  out  32  FIFO head word
- rnd_valid_o  out  1  FIFO not empty
- rnd_ready_i  in  1  pop; a word transfers when valid & ready
- fifo_level_o  out  $clog2(FIFO_DEPTH+1)  current occupancy
- gen_count_o  out  32  words pushed since last seed load; wraps at 2^32
- seed_zero_err_o  out  1  sticky; set when seed_i=0 was loaded; cleared only by reset

## Operation
- Next-state function: x ^= x<<13; x ^= x>>17; x ^= x<<5. All 32-bit, shifted-out bits dropped.
- FSM states:
  - IDLE: enable_i=0; nothing generated; the FIFO can still be popped.
  - WARMUP: advances the state every cycle without pushing, for WARMUP_WORDS cycles, then moves to RUN. enable_i=0 here holds the warm-up counter.
  - RUN: on each cycle with enable_i=1 and a free slot (full is allowed if a pop happens the same cycle), advance the state and push the new value.
- FSM transitions:
  - Reset → WARMUP if WARMUP_WORDS>0, else RUN. The state register starts at DEFAULT_SEED.
  - seed_load_i from any state → same rule as reset.
  - RUN ↔ IDLE follows enable_i.
- seed_load_i behaviour:
  - Loads state = seed_i. If seed_i=0, loads DEFAULT_SEED and sets seed_zero_err_o.
  - Empties the FIFO and clears gen_count_o.
  - Takes priority over a generate and a pop in the same cycle; the pop is discarded and the word is lost.
- FIFO:
  - Circular buffer with read/write pointers and an occupancy counter.
  - Push and pop in the same cycle keep the level unchanged.
  - Pop when empty is ignored. No push happens when full without a simultaneous pop.
  - rnd_data_o is driven from the buffer register at the read pointer; there is no combinational path from rnd_ready_i.
- gen_count_o increments once per push.

## Timing
- Reset values: state = DEFAULT_SEED; FIFO empty; rnd_valid_o = 0; rnd_data_o = 0; fifo_level_o = 0; gen_count_o = 0; seed_zero_err_o = 0.
- Seed load sampled at edge N with WARMUP_WORDS=0 and enable_i=1: first word pushed at edge N+1; rnd_valid_o high from cycle N+1.
- With warm-up W: the first push is at edge N+1+W.
- Steady state with ready held high: one word per cycle. rnd_valid_o never drops between words.
- Pop to refill: a pop at edge K frees a slot, and the push is allowed at edge K itself (same-cycle full+pop). A full FIFO with continuous ready therefore sustains 1 word/cycle.
- Reset asserted mid-operation: all outputs go to reset values immediately, without waiting for a clock edge.

## Structure
- Package rng_pkg holds:
  - the FSM state enum (IDLE, WARMUP, RUN);
  - the xorshift shift constants 13, 17, 5;
  - a function xorshift32_next(logic [31:0]) → logic [31:0], shared with the bench's reference model.
- One sub-module, rng_fifo: parameterised sync FIFO with a flush input, level output and same-cycle full-push/pop support. The core instantiates it.

## Test plan
- Seed 32'h00000001, WARMUP_WORDS=0, enable=1, ready=1 → words 0x00042021, then 0x04080601; gen_count_o = 2 after two pushes.
- Seed 0 → seed_zero_err_o = 1 and stays set; first word equals xorshift32_next(32'h2545F491); a later nonzero seed does not clear the flag.
- ready=0 with FIFO_DEPTH=4 → level rises to 4 and holds; gen_count_o stops at 4; ready=1 → 4 buffered words, then a fresh word every cycle with no gap.
- Seed load with a full FIFO and ready=1 in the same cycle → next cycle level=0, no word transferred; the word after that is xorshift32_next(seed).
- WARMUP_WORDS=3, seed 1 → rnd_valid_o rises at cycle N+4; the first word equals the 4th sequence value; dropping enable_i mid-warm-up delays valid by the same number of cycles.
- Reset asserted while streaming → rnd_valid_o = 0 and fifo_level_o = 0 asynchronously; after release, the first word equals xorshift32_next(32'h2545F491).

Source files
------------

// File: rtl/rng_pkg.sv
// Shared types, constants and next-state function for the
// xorshift32 random-word generator.
package rng_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WARMUP = 2'd1,
      RUN    = 2'd2
   } rng_state_e;

   localparam int unsigned SH_A = 13;
   localparam int unsigned SH_B = 17;
   localparam int unsigned SH_C = 5;

   function automatic logic [31:0] xorshift32_next(
      input logic [31:0] x
   );
      logic [31:0] t;
      t = x ^ (x << SH_A);
      t = t ^ (t >> SH_B);
      t = t ^ (t << SH_C);
      return t;
   endfunction

endpackage

// File: rtl/rng_fifo.sv
// Synchronous circular FIFO with flush, occupancy output and
// push-into-full allowed when a pop happens in the same cycle.
module rng_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             valid,
   output logic             full,
   output logic [LW-1:0]    level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    count;
   logic             do_pop;
   logic             do_push;

   assign valid   = (count != '0);
   assign full    = (count == LW'(DEPTH));
   assign level   = count;
   assign rd_data = mem[rd_ptr];
   assign do_pop  = pop && valid && !flush;
   assign do_push = push && (!full || do_pop) && !flush;

   // Storage array; cleared on reset so the head reads zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rng_xorshift_core.sv
// xorshift32 (13/17/5) generator with warm-up, seed handling
// and a FIFO-buffered valid/ready output port.
module rng_xorshift_core
   import rng_pkg::*;
#(
   parameter int          FIFO_DEPTH   = 4,
   parameter int          WARMUP_WORDS = 0,
   parameter logic [31:0] DEFAULT_SEED = 32'h2545F491,
   localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
   input  logic          s00_axi_aclk,
   input  logic          s00_axi_aresetn,
   input  logic [31:0]   seed_i,
   input  logic          seed_load_i,
   input  logic          enable_i,
   output logic [31:0]   rnd_data_o,
   output logic          rnd_valid_o,
   input  logic          rnd_ready_i,
   output logic [LW-1:0] fifo_level_o,
   output logic [31:0]   gen_count_o,
   output logic          seed_zero_err_o
);

   localparam logic [7:0] WARM_INIT = 8'(WARMUP_WORDS);
   localparam rng_state_e START_ST =
      (WARMUP_WORDS > 0) ? WARMUP : RUN;

   rng_state_e  state_q;
   rng_state_e  state_d;
   logic [31:0] x_q;
   logic [31:0] x_next;
   logic [7:0]  warm_q;
   logic [31:0] gen_q;
   logic        err_q;
   logic        full;
   logic        pop;
   logic        can_push;
   logic        push;
   logic        adv;

   assign x_next          = xorshift32_next(x_q);
   assign pop             = rnd_valid_o && rnd_ready_i;
   assign can_push        = !full || pop;
   assign gen_count_o     = gen_q;
   assign seed_zero_err_o = err_q;

   // Next state, generator advance and push decision.
   always_comb begin
      state_d = state_q;
      adv     = 1'b0;
      push    = 1'b0;
      if (seed_load_i) begin
         state_d = START_ST;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (enable_i) begin
                  state_d = RUN;
                  push    = can_push;
                  adv     = can_push;
               end
            end
            WARMUP: begin
               if (enable_i) begin
                  adv = 1'b1;
                  if (warm_q <= 8'd1) state_d = RUN;
               end
            end
            RUN: begin
               if (enable_i) begin
                  push = can_push;
                  adv  = can_push;
               end else begin
                  state_d = IDLE;
               end
            end
            default: state_d = START_ST;
         endcase
      end
   end

   // FSM state and warm-up countdown.
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         state_q <= START_ST;
         warm_q  <= WARM_INIT;
      end else begin
         state_q <= state_d;
         if (seed_load_i) begin
            warm_q <= WARM_INIT;
         end else if (state_q == WARMUP && enable_i) begin
            warm_q <= warm_q - 8'd1;
         end
      end
   end

   // Generator state, push counter and sticky zero-seed flag.
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         x_q   <= DEFAULT_SEED;
         gen_q <= '0;
         err_q <= 1'b0;
      end else if (seed_load_i) begin
         x_q   <= (seed_i == '0) ? DEFAULT_SEED : seed_i;
         gen_q <= '0;
         if (seed_i == '0) err_q <= 1'b1;
      end else begin
         if (adv)  x_q   <= x_next;
         if (push) gen_q <= gen_q + 32'd1;
      end
   end

   rng_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk       (s00_axi_aclk),
      .rst_n     (s00_axi_aresetn),
      .flush     (seed_load_i),
      .push      (push),
      .push_data (x_next),
      .pop       (pop),
      .rd_data   (rnd_data_o),
      .valid     (rnd_valid_o),
      .full      (full),
      .level     (fifo_level_o)
   );

endmodule
